// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone arbiter in front of one shared slave (SPI memory).
// m0 is instruction fetch and m1 is data.
// When both masters request, the arbiter alternates between them (round-robin).
// A grant starts one cycle after the request is sampled.
// Between two transfers there is always one idle cycle.
// A granted transfer that waits TIMEOUT cycles without s_ack_i is aborted,
// and the arbiter returns a one-cycle error to the owning master.
//
// Ports:
//   clk, rst              single clock; synchronous active-high reset
//   mX_adr_i/dat_i/we_i/sel_i/stb_i/cyc_i   master requests (X = 0, 1)
//   mX_ack_o/err_o/dat_o  per-master response; all zero unless that master owns the slave
//   s_adr_o/dat_o/we_o/sel_o/stb_o/cyc_o    shared slave request; all zero when idle
//   s_ack_i, s_dat_i      slave response
//   grant_o               one-hot owner (bit0 = m0, bit1 = m1); 2'b00 when idle
module wb_mem_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_dat_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  output logic [1:0]  grant_o
);

  localparam logic [7:0] WcntLast = TIMEOUT - 8'd1;

  typedef enum logic [1:0] {StIdle, StGrant0, StGrant1} state_e;

  state_e     state_q, state_d;
  logic       last_grant_q, last_grant_d;  // 0 = m0 owned last, 1 = m1
  logic [7:0] wcnt_q, wcnt_d;

  logic req0, req1;
  logic granted, own1;
  logic sel_cyc;
  logic timeout;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  // A cycle with rst high is treated as idle. A transfer cut off by reset
  // therefore never leaks an ack or an err.
  assign granted = (state_q != StIdle) && !rst;
  assign own1    = (state_q == StGrant1);
  assign sel_cyc = own1 ? m1_cyc_i : m0_cyc_i;
  assign timeout = (wcnt_q == WcntLast) && !s_ack_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      wcnt_q       <= 8'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wcnt_q       <= wcnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wcnt_d       = wcnt_q;
    case (state_q)
      StIdle: begin
        wcnt_d = 8'd0;
        if (req0 && req1) begin
          state_d = last_grant_q ? StGrant0 : StGrant1;
        end else if (req0) begin
          state_d = StGrant0;
        end else if (req1) begin
          state_d = StGrant1;
        end
      end
      StGrant0, StGrant1: begin
        // Ack, abandon and timeout all end the grant and record the owner.
        if (!sel_cyc || s_ack_i || timeout) begin
          state_d      = StIdle;
          last_grant_d = own1;
        end else if (wcnt_q != 8'hFF) begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output routing
  always_comb begin
    s_adr_o  = 32'd0;
    s_dat_o  = 32'd0;
    s_we_o   = 1'b0;
    s_sel_o  = 4'd0;
    s_stb_o  = 1'b0;
    s_cyc_o  = 1'b0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_dat_o = 32'd0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_dat_o = 32'd0;
    grant_o  = 2'b00;
    if (granted) begin
      if (own1) begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_stb_o  = m1_stb_i;
        s_cyc_o  = m1_cyc_i;
        // A master that has dropped cyc is not ending a transfer, so it gets no response.
        m1_ack_o = s_ack_i & m1_cyc_i;
        m1_err_o = timeout & m1_cyc_i;
        m1_dat_o = s_dat_i;
        grant_o  = 2'b10;
      end else begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_stb_o  = m0_stb_i;
        s_cyc_o  = m0_cyc_i;
        m0_ack_o = s_ack_i & m0_cyc_i;
        m0_err_o = timeout & m0_cyc_i;
        m0_dat_o = s_dat_i;
        grant_o  = 2'b01;
      end
    end
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
module tb_wb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, s_dat;
  logic        m0_we, m1_we, m0_stb, m1_stb, m0_cyc, m1_cyc, s_ack;
  logic [3:0]  m0_sel, m1_sel;

  // Outputs of dut (default TIMEOUT)
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdat, m1_rdat, s_adr, s_wdat;
  logic        s_we, s_stb, s_cyc;
  logic [3:0]  s_sel;
  logic [1:0]  grant;

  // Outputs of dut_t (TIMEOUT = 10)
  logic        t_m0_ack, t_m0_err, t_m1_ack, t_m1_err;
  logic [31:0] t_m0_rdat, t_m1_rdat, t_s_adr, t_s_wdat;
  logic        t_s_we, t_s_stb, t_s_cyc;
  logic [3:0]  t_s_sel;
  logic [1:0]  t_grant;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc),
    .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_dat_o(m0_rdat),
    .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_dat_o(m1_rdat),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_stb_o(s_stb), .s_cyc_o(s_cyc),
    .s_ack_i(s_ack), .s_dat_i(s_dat), .grant_o(grant)
  );

  wb_mem_arbiter #(.TIMEOUT(8'd10)) dut_t (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc),
    .m0_ack_o(t_m0_ack), .m0_err_o(t_m0_err), .m0_dat_o(t_m0_rdat),
    .m1_ack_o(t_m1_ack), .m1_err_o(t_m1_err), .m1_dat_o(t_m1_rdat),
    .s_adr_o(t_s_adr), .s_dat_o(t_s_wdat), .s_we_o(t_s_we), .s_sel_o(t_s_sel),
    .s_stb_o(t_s_stb), .s_cyc_o(t_s_cyc),
    .s_ack_i(s_ack), .s_dat_i(s_dat), .grant_o(t_grant)
  );

  typedef struct {
    logic       c0, c1, ack;       // inputs for this cycle (stb follows cyc)
    logic [1:0] gnt;               // expected grant_o
    logic       a0, a1, e0, e1;    // expected acks / errs
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    s_ack  = 1'b0; s_dat = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_adr, exp_cyc;
    logic        bad;

    m0_adr = 32'h1000_0100; m0_dat = 32'h0A0A_0A0A; m0_we = 1'b0; m0_sel = 4'hF;
    m1_adr = 32'h0000_0040; m1_dat = 32'h5151_5151; m1_we = 1'b0; m1_sel = 4'hF;

    //              c0    c1    ack   gnt    a0    a1    e0    e1
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0}; // m0 abandons
    vecs[11] = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0}; // stray ack in idle

    // Reset state
    do_reset();
    chk("reset grant", {30'd0, grant}, 32'd0);
    chk("reset s_cyc", {31'd0, s_cyc}, 32'd0);

    // Table: round-robin, abandon, idle isolation
    for (int i = 0; i < 15; i++) begin
      m0_cyc = vecs[i].c0; m0_stb = vecs[i].c0;
      m1_cyc = vecs[i].c1; m1_stb = vecs[i].c1;
      s_ack  = vecs[i].ack;
      s_dat  = 32'hA5A5_0000 + 32'(i);
      #1;
      exp_adr = (vecs[i].gnt == 2'b01) ? m0_adr : (vecs[i].gnt == 2'b10) ? m1_adr : 32'd0;
      exp_cyc = (vecs[i].gnt == 2'b01) ? {31'd0, vecs[i].c0} :
                (vecs[i].gnt == 2'b10) ? {31'd0, vecs[i].c1} : 32'd0;
      chk($sformatf("v%0d grant", i), {30'd0, grant}, {30'd0, vecs[i].gnt});
      chk($sformatf("v%0d m0_ack", i), {31'd0, m0_ack}, {31'd0, vecs[i].a0});
      chk($sformatf("v%0d m1_ack", i), {31'd0, m1_ack}, {31'd0, vecs[i].a1});
      chk($sformatf("v%0d m0_err", i), {31'd0, m0_err}, {31'd0, vecs[i].e0});
      chk($sformatf("v%0d m1_err", i), {31'd0, m1_err}, {31'd0, vecs[i].e1});
      chk($sformatf("v%0d s_adr", i), s_adr, exp_adr);
      chk($sformatf("v%0d s_cyc", i), {31'd0, s_cyc}, exp_cyc);
      chk($sformatf("v%0d m0_dat", i), m0_rdat, (vecs[i].gnt == 2'b01) ? s_dat : 32'd0);
      chk($sformatf("v%0d m1_dat", i), m1_rdat, (vecs[i].gnt == 2'b10) ? s_dat : 32'd0);
      tick();
    end

    // Single m1 read, slave acks after 66 cycles
    do_reset();
    m1_cyc = 1'b1; m1_stb = 1'b1;
    #1;
    chk("rd req cycle grant", {30'd0, grant}, 32'd0);
    tick();
    chk("rd grant", {30'd0, grant}, 32'h2);
    chk("rd s_stb", {31'd0, s_stb}, 32'd1);
    chk("rd s_adr", s_adr, 32'h0000_0040);
    chk("rd s_we", {31'd0, s_we}, 32'd0);
    bad = 1'b0;
    for (int k = 0; k < 65; k++) begin
      if (m0_ack || m0_err || m0_rdat != 0 || m1_ack || m1_err || grant != 2'b10) bad = 1'b1;
      tick();
    end
    chk("rd wait quiet", {31'd0, bad}, 32'd0);
    s_ack = 1'b1; s_dat = 32'hDEAD_BEEF;
    #1;
    chk("rd m1_ack", {31'd0, m1_ack}, 32'd1);
    chk("rd m1_dat", m1_rdat, 32'hDEAD_BEEF);
    chk("rd m1_err", {31'd0, m1_err}, 32'd0);
    chk("rd m0 quiet", {m0_rdat[31:2], m0_ack, m0_err}, 32'd0);
    tick();
    s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    #1;
    chk("rd done grant", {30'd0, grant}, 32'd0);

    // Timeout on dut_t (TIMEOUT = 10), m1 waiting behind
    do_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    tick();
    bad = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (t_m0_err || t_m1_err || t_m0_ack || t_grant != 2'b01) bad = 1'b1;
      tick();
    end
    chk("to early err", {31'd0, bad}, 32'd0);
    #1;
    chk("to m0_err", {31'd0, t_m0_err}, 32'd1);
    chk("to m0_ack", {31'd0, t_m0_ack}, 32'd0);
    chk("to m1_err", {31'd0, t_m1_err}, 32'd0);
    tick();
    chk("to idle grant", {30'd0, t_grant}, 32'd0);
    chk("to err one cycle", {31'd0, t_m0_err}, 32'd0);
    tick();
    chk("to m1 next", {30'd0, t_grant}, 32'h2);
    s_ack = 1'b1;
    #1;
    chk("to m1_ack", {31'd0, t_m1_ack}, 32'd1);
    tick();
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;

    // Ack coinciding with the timeout cycle
    do_reset();
    m1_cyc = 1'b1; m1_stb = 1'b1;
    tick();
    repeat (9) tick();
    s_ack = 1'b1; s_dat = 32'h1234_5678;
    #1;
    chk("ack@to m1_ack", {31'd0, t_m1_ack}, 32'd1);
    chk("ack@to m1_err", {31'd0, t_m1_err}, 32'd0);
    chk("ack@to m1_dat", t_m1_rdat, 32'h1234_5678);
    tick();
    s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    #1;
    chk("ack@to idle", {30'd0, t_grant}, 32'd0);

    // Reset pulsed during a GRANT1 transfer
    do_reset();
    m1_cyc = 1'b1; m1_stb = 1'b1;
    tick();
    chk("rst g1 grant", {30'd0, grant}, 32'h2);
    repeat (2) tick();
    rst = 1'b1; s_ack = 1'b1; m0_cyc = 1'b1; m0_stb = 1'b1;
    #1;
    chk("rst mid grant", {30'd0, grant}, 32'd0);
    chk("rst mid s_cyc", {31'd0, s_cyc}, 32'd0);
    chk("rst mid m1_ack", {31'd0, m1_ack}, 32'd0);
    chk("rst mid m1_err", {31'd0, m1_err}, 32'd0);
    tick();
    rst = 1'b0; s_ack = 1'b0;
    #1;
    chk("post rst grant", {30'd0, grant}, 32'd0);
    chk("post rst s_cyc", {31'd0, s_cyc}, 32'd0);
    tick();
    chk("post rst m0 wins", {30'd0, grant}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
